// File: rtl/aes_bram_pkg.sv
// Shared definitions for the AES BRAM port: state encoding, write-enable and
// error-data constants, and the legal read-latency range.
package aes_bram_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      DONE    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [3:0]  WE_ALL      = 4'hF;
   localparam logic [31:0] RD_ERR_DATA = 32'h0;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;

   // Out-of-range latencies are pulled to the nearest legal value.
   function automatic int clamp_latency(input int lat);
      if (lat < RD_LAT_MIN) return RD_LAT_MIN;
      if (lat > RD_LAT_MAX) return RD_LAT_MAX;
      return lat;
   endfunction

endpackage

// File: rtl/aes_lat_pipe.sv
// Valid shift register that marks the cycle in which an issued BRAM read is
// DEPTH cycles old.
module aes_lat_pipe #(
   parameter int DEPTH = 2
) (
   input  logic aes_clk,
   input  logic aes_rst_n,
   input  logic vld_in,
   output logic vld_out
);

   logic [DEPTH-1:0] vld_p;

   always_ff @(posedge aes_clk or negedge aes_rst_n) begin
      if (!aes_rst_n) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= vld_in;
         for (int i = 1; i < DEPTH; i++) begin
            vld_p[i] <= vld_p[i-1];
         end
      end
   end

   assign vld_out = vld_p[DEPTH-1];

endmodule

// File: rtl/aes_bram_port.sv
// Converts the AES sequencer's level-held read/write requests into single-cycle
// native BRAM accesses, with address policing and a completed-transfer counter.
module aes_bram_port
   import aes_bram_pkg::*;
#(
   parameter int          ADDR_W       = 12,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int          READ_LATENCY = 2
) (
   input  logic              aes_clk,
   input  logic              aes_rst_n,
   input  logic              req_read,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic [31:0]       rd_data,
   output logic              complete,
   output logic              busy,
   output logic              bram_en,
   output logic [3:0]        bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [31:0]       bram_din,
   input  logic [31:0]       bram_dout,
   output logic              err_addr,
   output logic              err_conflict,
   input  logic              err_clear,
   output logic [31:0]       xfer_count
);

   localparam int LAT = clamp_latency(READ_LATENCY);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] offset;
   logic        addr_ok;
   logic        req_any;
   logic        idle;
   logic        accept;
   logic        issue_rd;
   logic        issue_wr;
   logic        lat_done;
   logic        acc_read;
   logic        acc_bad;

   // Word index must fit the BRAM depth; anything above it is out of range.
   assign offset   = req_addr - BASE_ADDR;
   assign addr_ok  = (offset[1:0] == 2'b00) && (offset[31:ADDR_W+2] == '0);
   assign req_any  = req_read | req_write;
   assign idle     = (state == IDLE);
   assign accept   = idle & req_any;
   assign issue_wr = accept & req_write & addr_ok;
   assign issue_rd = accept & ~req_write & addr_ok;
   assign busy     = ~idle;

   aes_lat_pipe #(
      .DEPTH (LAT)
   ) u_lat_pipe (
      .aes_clk   (aes_clk),
      .aes_rst_n (aes_rst_n),
      .vld_in    (issue_rd),
      .vld_out   (lat_done)
   );

   always_ff @(posedge aes_clk or negedge aes_rst_n) begin
      if (!aes_rst_n) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_any)  state_nxt = issue_rd ? RD_WAIT : DONE;
         RD_WAIT: if (lat_done) state_nxt = DONE;
         DONE:                  state_nxt = RELEASE;
         RELEASE: if (!req_any) state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aes_clk or negedge aes_rst_n) begin
      if (!aes_rst_n) begin
         bram_en      <= 1'b0;
         bram_we      <= 4'h0;
         bram_addr    <= '0;
         bram_din     <= '0;
         acc_read     <= 1'b0;
         acc_bad      <= 1'b0;
         complete     <= 1'b0;
         rd_data      <= '0;
         xfer_count   <= '0;
         err_addr     <= 1'b0;
         err_conflict <= 1'b0;
      end else begin
         bram_en <= issue_rd | issue_wr;
         bram_we <= issue_wr ? WE_ALL : 4'h0;

         if (accept) begin
            acc_read <= ~req_write;
            acc_bad  <= ~addr_ok;
            if (addr_ok)   bram_addr <= offset[ADDR_W+1:2];
            if (req_write) bram_din  <= req_wdata;
         end

         // BRAM data is valid throughout DONE, so it is latched on the way out
         complete <= (state == DONE);
         if (state == DONE) begin
            xfer_count <= xfer_count + 32'd1;
            if (acc_read) rd_data <= acc_bad ? RD_ERR_DATA : bram_dout;
         end

         if (err_clear)                     err_addr <= 1'b0;
         else if (accept & ~addr_ok)        err_addr <= 1'b1;

         if (err_clear)                     err_conflict <= 1'b0;
         else if (accept & req_read & req_write) err_conflict <= 1'b1;
      end
   end

endmodule

// File: tb/tb_aes_bram_port.sv
// Testbench for aes_bram_port: directed vector table, hand-written corner
// sequences and random accesses checked against a transaction-level model.
module tb_aes_bram_port;

   localparam int          ADDR_W = 12;
   localparam logic [31:0] BASE   = 32'h0000_0000;
   localparam int          RL     = 2;
   localparam int          DEPTH  = 1 << ADDR_W;

   logic              aes_clk   = 1'b0;
   logic              aes_rst_n = 1'b0;
   logic              req_read  = 1'b0;
   logic              req_write = 1'b0;
   logic [31:0]       req_addr  = '0;
   logic [31:0]       req_wdata = '0;
   logic              err_clear = 1'b0;
   logic [31:0]       rd_data;
   logic              complete;
   logic              busy;
   logic              bram_en;
   logic [3:0]        bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [31:0]       bram_din;
   logic [31:0]       bram_dout;
   logic              err_addr;
   logic              err_conflict;
   logic [31:0]       xfer_count;

   always #5 aes_clk = ~aes_clk;

   aes_bram_port #(
      .ADDR_W       (ADDR_W),
      .BASE_ADDR    (BASE),
      .READ_LATENCY (RL)
   ) dut (
      .aes_clk      (aes_clk),
      .aes_rst_n    (aes_rst_n),
      .req_read     (req_read),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rd_data      (rd_data),
      .complete     (complete),
      .busy         (busy),
      .bram_en      (bram_en),
      .bram_we      (bram_we),
      .bram_addr    (bram_addr),
      .bram_din     (bram_din),
      .bram_dout    (bram_dout),
      .err_addr     (err_addr),
      .err_conflict (err_conflict),
      .err_clear    (err_clear),
      .xfer_count   (xfer_count)
   );

   // BRAM with RL-cycle read latency; stale cycles show a poison word
   logic [31:0] bram_mem [DEPTH];
   logic [31:0] rd_pipe  [RL];

   always @(posedge aes_clk) begin
      if (bram_en && bram_we == 4'hF) bram_mem[bram_addr] <= bram_din;
      rd_pipe[0] <= (bram_en && bram_we == 4'h0) ? bram_mem[bram_addr] : 32'hDEAD_BEEF;
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bram_dout = rd_pipe[RL-1];

   // Bus monitor
   int                cyc        = 0;
   int                en_pulses  = 0;
   int                en_double  = 0;
   int                cpl_pulses = 0;
   int                cpl_double = 0;
   int                en_cyc_q[$];
   logic              prev_en    = 1'b0;
   logic              prev_cpl   = 1'b0;
   logic [3:0]        last_we    = '0;
   logic [ADDR_W-1:0] last_addr  = '0;
   logic [31:0]       last_din   = '0;

   always @(negedge aes_clk) begin
      cyc = cyc + 1;
      if (bram_en) begin
         en_pulses = en_pulses + 1;
         en_cyc_q.push_back(cyc);
         last_we   = bram_we;
         last_addr = bram_addr;
         last_din  = bram_din;
         if (prev_en) en_double = en_double + 1;
      end
      if (complete) begin
         cpl_pulses = cpl_pulses + 1;
         if (prev_cpl) cpl_double = cpl_double + 1;
      end
      prev_en  = bram_en;
      prev_cpl = complete;
   end

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          clr_before;
   } stim_t;

   typedef struct {
      int                lat;
      logic [31:0]       data;
      int                en;
      logic [3:0]        we;
      logic [ADDR_W-1:0] baddr;
      logic [31:0]       din;
      bit                ea;
      bit                ec;
      logic [31:0]       xfer;
   } exp_t;

   typedef struct {
      stim_t s;
      exp_t  e;
   } vec_t;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Transaction-level reference model
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] ref_rd   = '0;
   bit          ref_ea   = 1'b0;
   bit          ref_ec   = 1'b0;
   logic [31:0] ref_xfer = '0;

   function automatic logic [31:0] init_word(input int i);
      return 32'h1000_0000 + 32'(i);
   endfunction

   function automatic exp_t model_step(input stim_t s);
      exp_t        e;
      int unsigned off;
      bit          legal;
      int          w;
      off   = s.addr - BASE;
      legal = (off % 4 == 0) && (off / 4 < DEPTH);
      w     = legal ? int'(off / 4) : 0;
      if (s.clr_before) begin
         ref_ea = 1'b0;
         ref_ec = 1'b0;
      end
      if (s.rd && s.wr) ref_ec = 1'b1;
      if (!legal)       ref_ea = 1'b1;
      e.en = 0; e.we = 4'h0; e.baddr = '0; e.din = '0;
      if (s.wr) begin
         e.lat = 1;
         if (legal) begin
            ref_mem[w] = s.wdata;
            e.en = 1; e.we = 4'hF; e.baddr = ADDR_W'(w); e.din = s.wdata;
         end
      end else if (legal) begin
         e.lat  = RL + 1;
         ref_rd = ref_mem[w];
         e.en = 1; e.baddr = ADDR_W'(w);
      end else begin
         e.lat  = 1;
         ref_rd = 32'h0;
      end
      ref_xfer = ref_xfer + 32'd1;
      e.data = ref_rd; e.ea = ref_ea; e.ec = ref_ec; e.xfer = ref_xfer;
      return e;
   endfunction

   function automatic vec_t mkv(input bit rd, input bit wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input int lat, input logic [31:0] data,
                                input int en, input logic [3:0] we, input logic [ADDR_W-1:0] baddr,
                                input logic [31:0] din, input bit ea, input bit ec,
                                input logic [31:0] xfer);
      vec_t v;
      v.s = '{rd: rd, wr: wr, addr: addr, wdata: wdata, clr_before: 1'b0};
      v.e = '{lat: lat, data: data, en: en, we: we, baddr: baddr, din: din, ea: ea, ec: ec, xfer: xfer};
      return v;
   endfunction

   // Sequencer-style access; called at posedge+1, returns at posedge+1
   task automatic do_access(input stim_t s, output exp_t o);
      int en0;
      int lat;
      en0       = en_pulses;
      req_read  = s.rd;
      req_write = s.wr;
      req_addr  = s.addr;
      req_wdata = s.wdata;
      @(posedge aes_clk);
      #1;
      req_addr  = $urandom;
      req_wdata = $urandom;
      lat = -1;
      do begin
         @(negedge aes_clk);
         lat++;
      end while (!complete && lat < 40);
      o.lat  = complete ? lat : -1;
      o.data = rd_data;
      o.ea   = err_addr;
      o.ec   = err_conflict;
      o.xfer = xfer_count;
      @(posedge aes_clk);
      #1;
      req_read  = 1'b0;
      req_write = 1'b0;
      @(posedge aes_clk);
      #1;
      o.en    = en_pulses - en0;
      o.we    = last_we;
      o.baddr = last_addr;
      o.din   = last_din;
   endtask

   task automatic compare(input string tag, input exp_t o, input exp_t e);
      check({tag, ".latency"}, 32'(o.lat), 32'(e.lat));
      check({tag, ".rd_data"}, o.data, e.data);
      check({tag, ".en_pulses"}, 32'(o.en), 32'(e.en));
      check({tag, ".err_addr"}, 32'(o.ea), 32'(e.ea));
      check({tag, ".err_conflict"}, 32'(o.ec), 32'(e.ec));
      check({tag, ".xfer_count"}, o.xfer, e.xfer);
      if (e.en != 0) begin
         check({tag, ".bram_addr"}, 32'(o.baddr), 32'(e.baddr));
         check({tag, ".bram_we"}, 32'(o.we), 32'(e.we));
         if (e.we != 4'h0) check({tag, ".bram_din"}, o.din, e.din);
      end
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      @(posedge aes_clk);
      #1;
      err_clear = 1'b0;
   endtask

   vec_t  tbl[12];
   stim_t s;
   exp_t  e;
   exp_t  o;

   initial begin
      int qs0;
      int cpl0;
      int lat;

      for (int i = 0; i < DEPTH; i++) begin
         bram_mem[i] = init_word(i);
         ref_mem[i]  = init_word(i);
      end
      bram_mem[5] = 32'hCAFE_F00D;
      ref_mem[5]  = 32'hCAFE_F00D;
      for (int i = 0; i < RL; i++) rd_pipe[i] = 32'hDEAD_BEEF;

      //                rd wr addr          wdata         lat data          en we    baddr     din           ea ec xfer
      tbl[0]  = mkv(1, 0, 32'h0000_0014, 32'h0,        3, 32'hCAFE_F00D, 1, 4'h0, 12'd5,    32'h0,        0, 0, 1);
      tbl[1]  = mkv(0, 1, 32'h0000_0020, 32'h1234_5678, 1, 32'hCAFE_F00D, 1, 4'hF, 12'd8,    32'h1234_5678, 0, 0, 2);
      tbl[2]  = mkv(1, 0, 32'h0000_0020, 32'h0,        3, 32'h1234_5678, 1, 4'h0, 12'd8,    32'h0,        0, 0, 3);
      tbl[3]  = mkv(1, 0, 32'h0000_0002, 32'h0,        1, 32'h0,         0, 4'h0, 12'd0,    32'h0,        1, 0, 4);
      tbl[4]  = mkv(1, 0, 32'h0000_4000, 32'h0,        1, 32'h0,         0, 4'h0, 12'd0,    32'h0,        1, 0, 5);
      tbl[5]  = mkv(1, 1, 32'h0000_0030, 32'hA5A5_0001, 1, 32'h0,         1, 4'hF, 12'd12,   32'hA5A5_0001, 1, 1, 6);
      tbl[6]  = mkv(1, 0, 32'h0000_0030, 32'h0,        3, 32'hA5A5_0001, 1, 4'h0, 12'd12,   32'h0,        1, 1, 7);
      tbl[7]  = mkv(1, 0, 32'h0000_3FFC, 32'h0,        3, 32'h1000_0FFF, 1, 4'h0, 12'hFFF,  32'h0,        1, 1, 8);
      tbl[8]  = mkv(0, 1, 32'h0000_4000, 32'hDEAD_DEAD, 1, 32'h1000_0FFF, 0, 4'h0, 12'd0,    32'h0,        1, 1, 9);
      tbl[9]  = mkv(1, 0, 32'h0000_0000, 32'h0,        3, 32'h1000_0000, 1, 4'h0, 12'd0,    32'h0,        1, 1, 10);
      tbl[10] = mkv(0, 1, 32'h0000_0021, 32'h5555_AAAA, 1, 32'h1000_0000, 0, 4'h0, 12'd0,    32'h0,        1, 1, 11);
      tbl[11] = mkv(1, 0, 32'h0000_0020, 32'h0,        3, 32'h1234_5678, 1, 4'h0, 12'd8,    32'h0,        1, 1, 12);

      // reset state
      repeat (3) @(posedge aes_clk);
      #1;
      check("reset.rd_data", rd_data, 32'h0);
      check("reset.complete", 32'(complete), 32'h0);
      check("reset.busy", 32'(busy), 32'h0);
      check("reset.bram_en", 32'(bram_en), 32'h0);
      check("reset.bram_we", 32'(bram_we), 32'h0);
      check("reset.bram_addr", 32'(bram_addr), 32'h0);
      check("reset.bram_din", bram_din, 32'h0);
      check("reset.err_addr", 32'(err_addr), 32'h0);
      check("reset.err_conflict", 32'(err_conflict), 32'h0);
      check("reset.xfer_count", xfer_count, 32'h0);
      aes_rst_n = 1'b1;
      @(posedge aes_clk);
      #1;

      // directed table
      for (int i = 0; i < 12; i++) begin
         e = model_step(tbl[i].s);
         do_access(tbl[i].s, o);
         compare($sformatf("vec%0d", i), o, tbl[i].e);
      end

      // err_clear drops both sticky flags
      pulse_clear();
      ref_ea = 1'b0;
      ref_ec = 1'b0;
      check("clear.err_addr", 32'(err_addr), 32'h0);
      check("clear.err_conflict", 32'(err_conflict), 32'h0);

      // set again, then clear in the very edge that would set it
      s = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0002, wdata: 32'h0, clr_before: 1'b0};
      e = model_step(s);
      do_access(s, o);
      compare("reset_err", o, e);
      req_read  = 1'b1;
      req_addr  = 32'h0000_0006;
      err_clear = 1'b1;
      @(posedge aes_clk);
      #1;
      err_clear = 1'b0;
      ref_ea    = 1'b0;
      ref_ec    = 1'b0;
      ref_xfer  = ref_xfer + 32'd1;
      ref_rd    = 32'h0;
      lat = -1;
      do begin
         @(negedge aes_clk);
         lat++;
         if (lat == 0) check("clr_prio.err_addr", 32'(err_addr), 32'h0);
      end while (!complete && lat < 40);
      check("clr_prio.latency", 32'(complete ? lat : -1), 32'd1);
      check("clr_prio.rd_data", rd_data, 32'h0);
      check("clr_prio.xfer_count", xfer_count, ref_xfer);
      @(posedge aes_clk);
      #1;
      req_read = 1'b0;
      @(posedge aes_clk);
      #1;
      check("clr_prio.err_addr_after", 32'(err_addr), 32'h0);

      // eight back-to-back reads at the sequencer's pace
      qs0  = en_cyc_q.size();
      cpl0 = cpl_pulses;
      for (int i = 0; i < 8; i++) begin
         s = '{rd: 1'b1, wr: 1'b0, addr: 32'(i * 4), wdata: 32'h0, clr_before: 1'b0};
         e = model_step(s);
         do_access(s, o);
         compare($sformatf("seq8_%0d", i), o, e);
      end
      check("seq8.en_pulses", 32'(en_cyc_q.size() - qs0), 32'd8);
      check("seq8.complete_pulses", 32'(cpl_pulses - cpl0), 32'd8);
      if (en_cyc_q.size() - qs0 == 8) begin
         for (int i = 1; i < 8; i++)
            check($sformatf("seq8.spacing%0d", i),
                  32'(en_cyc_q[qs0+i] - en_cyc_q[qs0+i-1]), 32'(RL + 4));
      end

      // reset in the middle of a read
      req_read = 1'b1;
      req_addr = 32'h0000_0014;
      @(posedge aes_clk);
      #2;
      check("rstmid.bram_en_before", 32'(bram_en), 32'h1);
      check("rstmid.busy_before", 32'(busy), 32'h1);
      aes_rst_n = 1'b0;
      #1;
      check("rstmid.bram_en", 32'(bram_en), 32'h0);
      check("rstmid.bram_we", 32'(bram_we), 32'h0);
      check("rstmid.busy", 32'(busy), 32'h0);
      check("rstmid.complete", 32'(complete), 32'h0);
      check("rstmid.xfer_count", xfer_count, 32'h0);
      check("rstmid.err_addr", 32'(err_addr), 32'h0);
      req_read = 1'b0;
      cpl0 = cpl_pulses;
      repeat (2) @(posedge aes_clk);
      #1;
      aes_rst_n = 1'b1;
      repeat (8) @(posedge aes_clk);
      #1;
      check("rstmid.no_complete", 32'(cpl_pulses - cpl0), 32'h0);
      check("rstmid.rd_data", rd_data, 32'h0);
      ref_xfer = '0;
      ref_ea   = 1'b0;
      ref_ec   = 1'b0;
      ref_rd   = 32'h0;
      s = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0014, wdata: 32'h0, clr_before: 1'b0};
      e = model_step(s);
      do_access(s, o);
      compare("post_reset_read", o, e);

      // random traffic
      for (int n = 0; n < 120; n++) begin
         int k;
         int a;
         k = int'($urandom_range(0, 15));
         s.rd = (k <= 7) || (k == 15);
         s.wr = (k >= 8);
         a = int'($urandom_range(0, 19));
         if (a < 16)       s.addr = 32'($urandom_range(0, 31)) * 4;
         else if (a < 18)  s.addr = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
         else if (a == 18) s.addr = 32'h0000_4000 + 32'($urandom_range(0, 1000)) * 4;
         else              s.addr = 32'h0000_3FF0 + 32'($urandom_range(0, 3)) * 4;
         s.wdata      = $urandom;
         s.clr_before = ($urandom_range(0, 7) == 0);
         if (s.clr_before) pulse_clear();
         e = model_step(s);
         do_access(s, o);
         compare($sformatf("rnd%0d", n), o, e);
      end

      check("bus.en_back_to_back", 32'(en_double), 32'h0);
      check("bus.complete_back_to_back", 32'(cpl_double), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/aes_bram_port.md
# aes_bram_port

Memory-side companion to the AES top-level sequencer. Converts its level-held `start_read`/`start_write` request and single `complete` reply into native single-port BRAM cycles: one-cycle enable, byte-to-word address translation, configurable read latency, and return-to-zero sequencing. It also polices address range and alignment, and keeps a debug transaction counter.

## Interface
- `ADDR_W`, 12: BRAM word-address width; depth = 2^ADDR_W words of 32 bits.
- `BASE_ADDR`, 32'h0000_0000: byte address of BRAM word 0; must be 4-byte aligned.
- `READ_LATENCY`, 2: cycles from the BRAM sampling `bram_en` to valid `bram_dout`; legal values 1..4.
- `aes_clk`  in  1  clock.
- `aes_rst_n`  in  1  reset, asynchronous, active-low.
- `req_read`  in  1  read request, level, held until `complete` seen.
- `req_write`  in  1  write request, level, held until `complete` seen.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  write data.
- `rd_data`  out  32  registered read data; valid while `complete`=1, held after.
- `complete`  out  1  one-cycle pulse ending the access.
- `busy`  out  1  high in any state other than IDLE.
- `bram_en`  out  1  BRAM enable.
- `bram_we`  out  4  byte write enables: 4'hF on write, 0 otherwise.
- `bram_addr`  out  ADDR_W  word address.
- `bram_din`  out  32  write data to BRAM.
- `bram_dout`  in  32  read data from BRAM.
- `err_addr`  out  1  sticky flag: out-of-range or misaligned request.
- `err_conflict`  out  1  sticky flag: read and write requested together.
- `err_clear`  in  1  synchronous clear of both sticky flags.
- `xfer_count`  out  32  count of completed accesses; wraps at 2^32.

## Operation
- States are IDLE, RD_WAIT, DONE and RELEASE.
- **IDLE**
  - Samples the requests. Offset = `req_addr` − `BASE_ADDR`, taken as unsigned 32-bit.
  - Legal request: offset[1:0]=0 and offset[31:2] < 2^ADDR_W.
  - Legal read: `bram_en`=1 for exactly one cycle with `bram_addr`=offset[ADDR_W+1:2]; go to RD_WAIT.
  - Legal write: `bram_en`=1, `bram_we`=4'hF, `bram_din`=`req_wdata` for one cycle; go to DONE.
- **Illegal address**
  - No BRAM cycle is issued; `err_addr` is set.
  - A read returns `rd_data`=32'h0.
  - Go straight to DONE, so the requester never hangs.
- **Simultaneous `req_read` and `req_write`:** the write wins and `err_conflict` is set.
- **RD_WAIT:** counts READ_LATENCY cycles, then captures `bram_dout` into `rd_data` and goes to DONE.
- **DONE:** `complete`=1 for one cycle, `xfer_count` increments, then go to RELEASE.
- **RELEASE**
  - Waits until both requests are sampled low, then returns to IDLE.
  - A request still high here (the requester has not yet seen `complete`) never starts a new access.
- **Address capture:** `req_addr` and `req_wdata` are captured only in IDLE. Later changes are ignored until the next access.
- **Clearing flags:** `err_clear` takes priority over a same-cycle set (the flag reads 0 after that edge).

## Timing
- **Reset values:** every output is 0, state is IDLE, and `xfer_count`=0.
- **Asserting reset mid-access:**
  - `bram_en` and `bram_we` drop immediately (asynchronous).
  - No `complete` is issued and the in-flight read data is discarded.
- **Read latency:** request sampled at edge k; `bram_en` high during cycle k..k+1; `rd_data` and `complete` appear after edge k+1+READ_LATENCY.
  - Request-to-`complete` is READ_LATENCY+1 cycles (3 at the default).
- **Write latency:** request sampled at edge k; `bram_en`/`bram_we` high during cycle k..k+1; `complete` appears after edge k+1.
- **Illegal request:** `complete` appears after edge k+1, with no BRAM activity.
- **Back-to-back accesses:** the requester drops its request on the edge where it sees `complete` and may re-raise it one cycle later.
  - RELEASE sees the low level and IDLE accepts the new request.
  - Sustained rate is one read per READ_LATENCY+4 cycles.
- **Enable shape:** `bram_en` is never high for two consecutive cycles.

## Structure
- Package `aes_bram_pkg` holds:
  - the state encoding (IDLE, RD_WAIT, DONE, RELEASE);
  - constants `WE_ALL`=4'hF and `RD_ERR_DATA`=32'h0;
  - the legal READ_LATENCY bounds, MIN 1 and MAX 4.
- Sub-module `aes_lat_pipe`: a parameterised valid shift register of depth READ_LATENCY. It marks when `bram_dout` is to be captured and replaces the RD_WAIT counter.

## Test plan
- **Read:** BRAM word 5 = 32'hCAFEF00D, `req_read` with `req_addr`=32'h14 → `bram_addr`=5; `complete` 3 cycles after the request is sampled; `rd_data`=32'hCAFEF00D.
- **Write then read-back:** write 32'h1234_5678 to 32'h20 → `bram_we`=4'hF for one cycle and `complete` after 1 cycle. A subsequent read of 32'h20 returns 32'h1234_5678.
- **Eight-word sequence:** model the sequencer's request pattern (drop on `complete`, re-raise one cycle later) for 8 reads. Expect 8 `complete` pulses, 8 single-cycle `bram_en` pulses, `xfer_count`=8, and no duplicate access.
- **Illegal addresses:** `req_addr`=32'h2 (misaligned) and 32'h4000 (out of range with ADDR_W=12) → `err_addr`=1, no `bram_en`, `complete` after 1 cycle, `rd_data`=0. Then `err_clear` → `err_addr`=0.
- **Conflict:** `req_read` and `req_write` raised together → a write cycle only, `err_conflict`=1.
- **Reset mid-read:** drop `aes_rst_n` in RD_WAIT → outputs 0 immediately, no `complete`. After release, a new read completes normally.
